// File: rtl/k423_lsu_ctrl.sv
// LSU sequencing controller: holds one decoded memory op through a valid/ready
// request, returns lane-aligned load data, flags misalignment and honours flush.
`ifndef LS_SIZE_W
`define LS_SIZE_W 2
`endif
`ifndef LS_SIZE_BYTE
`define LS_SIZE_BYTE 2'd0
`endif
`ifndef LS_SIZE_HALF
`define LS_SIZE_HALF 2'd1
`endif
`ifndef LS_SIZE_WORD
`define LS_SIZE_WORD 2'd2
`endif

module k423_lsu_ctrl #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  lsu_req_vld_i,
    input  logic                  lsu_req_load_i,
    input  logic                  lsu_req_unsigned_i,
    input  logic [`LS_SIZE_W-1:0] lsu_req_size_i,
    input  logic [ADDR_W-1:0]     lsu_req_addr_i,
    input  logic [XLEN-1:0]       lsu_req_wdata_i,
    input  logic                  flush_i,
    output logic                  lsu_stall_o,
    output logic                  lsu_done_o,
    output logic [XLEN-1:0]       lsu_rdata_o,
    output logic                  lsu_misalign_o,
    output logic                  mem_req_vld_o,
    output logic [3:0]            mem_req_wen_o,
    output logic [ADDR_W-1:0]     mem_req_addr_o,
    output logic [XLEN-1:0]       mem_req_wdata_o,
    input  logic                  mem_req_rdy_i,
    input  logic                  mem_rsp_vld_i,
    input  logic [XLEN-1:0]       mem_rsp_rdata_i
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

    state_t                state_q, state_d;
    logic                  load_q, load_d;
    logic                  uns_q, uns_d;
    logic                  kill_q, kill_d;
    logic [`LS_SIZE_W-1:0] size_q, size_d;
    logic [1:0]            off_q, off_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [3:0]            wen_q, wen_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [XLEN-1:0]       rdata_q, rdata_d;

    logic                  mis_raw;
    logic                  req_ok;
    logic [3:0]            st_wen;
    logic [XLEN-1:0]       st_wdata;
    logic [XLEN-1:0]       rsp_s;
    logic [XLEN-1:0]       ld_res;

    // Request-side decode: alignment check and store lane placement.
    always_comb begin
        mis_raw  = 1'b0;
        st_wen   = 4'b1111;
        st_wdata = lsu_req_wdata_i;
        case (lsu_req_size_i)
            `LS_SIZE_BYTE: begin
                st_wen   = 4'b0001 << lsu_req_addr_i[1:0];
                st_wdata = {(XLEN/8){lsu_req_wdata_i[7:0]}};
            end
            `LS_SIZE_HALF: begin
                mis_raw  = lsu_req_addr_i[0];
                st_wen   = 4'b0011 << lsu_req_addr_i[1:0];
                st_wdata = {(XLEN/16){lsu_req_wdata_i[15:0]}};
            end
            default: mis_raw = |lsu_req_addr_i[1:0];
        endcase
    end

    assign req_ok = lsu_req_vld_i & ~flush_i & ~mis_raw;
    assign rsp_s  = mem_rsp_rdata_i >> {off_q, 3'b000};

    always_comb begin
        case (size_q)
            `LS_SIZE_BYTE: ld_res = {{(XLEN-8){~uns_q & rsp_s[7]}}, rsp_s[7:0]};
            `LS_SIZE_HALF: ld_res = {{(XLEN-16){~uns_q & rsp_s[15]}}, rsp_s[15:0]};
            default:       ld_res = rsp_s;
        endcase
    end

    always_comb begin
        state_d = state_q;
        load_d  = load_q;
        uns_d   = uns_q;
        kill_d  = kill_q;
        size_d  = size_q;
        off_d   = off_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_ok) begin
                    load_d  = lsu_req_load_i;
                    uns_d   = lsu_req_unsigned_i;
                    size_d  = lsu_req_size_i;
                    off_d   = lsu_req_addr_i[1:0];
                    addr_d  = {lsu_req_addr_i[ADDR_W-1:2], 2'b00};
                    wen_d   = lsu_req_load_i ? 4'b0000 : st_wen;
                    wdata_d = st_wdata;
                    kill_d  = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // A flush coinciding with the handshake cannot recall the request;
                // loads still wait out their response, marked killed.
                if (mem_req_rdy_i) begin
                    if (load_q) begin
                        state_d = S_RESP;
                        kill_d  = flush_i;
                    end else begin
                        state_d = flush_i ? S_IDLE : S_DONE;
                    end
                end else if (flush_i) begin
                    state_d = S_IDLE;
                end
            end
            S_RESP: begin
                if (mem_rsp_vld_i) begin
                    if (!(kill_q | flush_i)) rdata_d = ld_res;
                    state_d = (kill_q | flush_i) ? S_IDLE : S_DONE;
                    kill_d  = 1'b0;
                end else if (flush_i) begin
                    kill_d = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            load_q  <= 1'b0;
            uns_q   <= 1'b0;
            kill_q  <= 1'b0;
            size_q  <= '0;
            off_q   <= '0;
            addr_q  <= '0;
            wen_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            uns_q   <= uns_d;
            kill_q  <= kill_d;
            size_q  <= size_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign lsu_stall_o     = ((state_q == S_IDLE) & req_ok) | (state_q == S_REQ) | (state_q == S_RESP);
    assign lsu_misalign_o  = (state_q == S_IDLE) & lsu_req_vld_i & ~flush_i & mis_raw;
    assign lsu_done_o      = (state_q == S_DONE);
    assign lsu_rdata_o     = rdata_q;
    assign mem_req_vld_o   = (state_q == S_REQ);
    assign mem_req_wen_o   = (state_q == S_REQ) ? wen_q : 4'b0000;
    assign mem_req_addr_o  = addr_q;
    assign mem_req_wdata_o = wdata_q;

endmodule

// File: tb/tb_k423_lsu_ctrl.sv
// Scoreboard bench for k423_lsu_ctrl: driver pushes expectations, memory and
// completion monitors pop and compare against a byte-level reference model.
`ifndef LS_SIZE_W
`define LS_SIZE_W 2
`endif
`ifndef LS_SIZE_BYTE
`define LS_SIZE_BYTE 2'd0
`endif
`ifndef LS_SIZE_HALF
`define LS_SIZE_HALF 2'd1
`endif
`ifndef LS_SIZE_WORD
`define LS_SIZE_WORD 2'd2
`endif

module tb_k423_lsu_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        lsu_req_vld_i = 1'b0, lsu_req_load_i = 1'b0, lsu_req_unsigned_i = 1'b0;
    logic [1:0]  lsu_req_size_i = '0;
    logic [31:0] lsu_req_addr_i = '0, lsu_req_wdata_i = '0;
    logic        flush_i = 1'b0;
    logic        lsu_stall_o, lsu_done_o, lsu_misalign_o;
    logic [31:0] lsu_rdata_o;
    logic        mem_req_vld_o;
    logic [3:0]  mem_req_wen_o;
    logic [31:0] mem_req_addr_o, mem_req_wdata_o;
    logic        mem_req_rdy_i = 1'b0, mem_rsp_vld_i = 1'b0;
    logic [31:0] mem_rsp_rdata_i = '0;

    k423_lsu_ctrl #(.ADDR_W(32), .XLEN(32)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .lsu_req_vld_i(lsu_req_vld_i), .lsu_req_load_i(lsu_req_load_i),
        .lsu_req_unsigned_i(lsu_req_unsigned_i), .lsu_req_size_i(lsu_req_size_i),
        .lsu_req_addr_i(lsu_req_addr_i), .lsu_req_wdata_i(lsu_req_wdata_i),
        .flush_i(flush_i), .lsu_stall_o(lsu_stall_o), .lsu_done_o(lsu_done_o),
        .lsu_rdata_o(lsu_rdata_o), .lsu_misalign_o(lsu_misalign_o),
        .mem_req_vld_o(mem_req_vld_o), .mem_req_wen_o(mem_req_wen_o),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_wdata_o(mem_req_wdata_o),
        .mem_req_rdy_i(mem_req_rdy_i), .mem_rsp_vld_i(mem_rsp_vld_i),
        .mem_rsp_rdata_i(mem_rsp_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {logic [3:0] wen; logic [31:0] addr; logic [31:0] wdata; logic is_load;} req_t;

    int          total = 0, bad = 0, cyc = 0;
    int          done_cnt = 0, done_cyc = 0, hs_cnt = 0;
    req_t        exp_req[$];
    logic [31:0] exp_done[$];
    int          rdyw_q[$], rspw_q[$];
    logic [31:0] rspd_q[$];
    logic [31:0] last_load = '0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: byte-level arithmetic on lanes.
    function automatic int nb(input logic [1:0] sz);
        return (sz == `LS_SIZE_BYTE) ? 1 : (sz == `LS_SIZE_HALF) ? 2 : 4;
    endfunction

    function automatic logic [3:0] e_wen(input int n, input int off);
        logic [3:0] r = '0;
        for (int i = 0; i < 4; i++) r[i] = (i >= off) && (i < off + n);
        return r;
    endfunction

    function automatic logic [31:0] e_wdata(input logic [31:0] wd, input int n);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] e_load(input logic [31:0] w, input int n, input int off, input bit uns);
        longint v = 0;
        for (int k = 0; k < n; k++) v += longint'(w[8*(off+k) +: 8]) << (8*k);
        if (!uns && n < 4 && v >= (longint'(1) << (8*n-1))) v -= (longint'(1) << (8*n));
        return v[31:0];
    endfunction

    // Memory model: per-op ready delay, response delay and data come from queues.
    int mm_rdy = 0, mm_rsp = -1;
    bit mm_in = 1'b0;
    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            mem_req_rdy_i = 1'b0; mem_rsp_vld_i = 1'b0; mm_in = 1'b0; mm_rsp = -1;
        end else begin
            mem_rsp_vld_i = 1'b0;
            mem_rsp_rdata_i = $urandom;
            if (mm_rsp == 0) begin
                mem_rsp_vld_i = 1'b1;
                mem_rsp_rdata_i = (rspd_q.size() != 0) ? rspd_q.pop_front() : $urandom;
                mm_rsp = -1;
            end else if (mm_rsp > 0) mm_rsp--;
            mem_req_rdy_i = 1'b0;
            if (mem_req_vld_o) begin
                if (!mm_in) begin
                    mm_in = 1'b1;
                    mm_rdy = (rdyw_q.size() != 0) ? rdyw_q.pop_front() : 0;
                end
                if (exp_req.size() == 0) begin
                    total++; bad++;
                    $display("FAIL req_unexpected: got addr %0h want no request", mem_req_addr_o);
                end else begin
                    chk("req_addr", mem_req_addr_o, exp_req[0].addr);
                    chk("req_wen", mem_req_wen_o, exp_req[0].wen);
                    if (!exp_req[0].is_load) chk("req_wdata", mem_req_wdata_o, exp_req[0].wdata);
                    if (mm_rdy == 0) begin
                        mem_req_rdy_i = 1'b1;
                        mm_in = 1'b0;
                        if (exp_req[0].is_load) begin
                            mm_rsp = (rspw_q.size() != 0) ? rspw_q.pop_front() : 0;
                            hs_cnt++;
                        end
                        void'(exp_req.pop_front());
                    end else mm_rdy--;
                end
            end else mm_in = 1'b0;
            // Stray response pulses while nothing is outstanding must be ignored.
            if (mm_rsp < 0 && !mem_rsp_vld_i && $urandom_range(0, 7) == 0) mem_rsp_vld_i = 1'b1;
        end
    end

    // Completion monitor.
    always @(negedge clk_i) begin
        if (rst_n_i && lsu_done_o) begin
            if (exp_done.size() == 0) begin
                total++; bad++;
                $display("FAIL done_unexpected: got done=1 want no completion (t=%0t)", $time);
            end else begin
                chk("done_rdata", lsu_rdata_o, exp_done.pop_front());
                chk("done_stall", lsu_stall_o, 0);
            end
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic drive(input bit ld, input bit uns, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        lsu_req_vld_i = 1'b1; lsu_req_load_i = ld; lsu_req_unsigned_i = uns;
        lsu_req_size_i = sz; lsu_req_addr_i = a; lsu_req_wdata_i = wd;
    endtask

    task automatic release_req();
        lsu_req_vld_i = 1'b0; lsu_req_addr_i = $urandom; lsu_req_wdata_i = $urandom;
        lsu_req_size_i = 2'($urandom_range(0, 2)); lsu_req_load_i = 1'($urandom);
    endtask

    task automatic push_exp(input bit ld, input bit uns, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, input int rw, input int pw,
                            input logic [31:0] rword, input bit want_done);
        req_t r;
        int n = nb(sz);
        int off = int'(a[1:0]);
        r.is_load = ld; r.addr = {a[31:2], 2'b00};
        r.wen = ld ? 4'b0000 : e_wen(n, off);
        r.wdata = e_wdata(wd, n);
        exp_req.push_back(r);
        rdyw_q.push_back(rw);
        if (ld) begin rspw_q.push_back(pw); rspd_q.push_back(rword); end
        if (want_done) begin
            if (ld) last_load = e_load(rword, n, off, uns);
            exp_done.push_back(last_load);
        end
    endtask

    task automatic issue(input bit ld, input bit uns, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input int rw, input int pw, input logic [31:0] rword);
        int c0, dc0, n;
        n = nb(sz);
        @(negedge clk_i); #1;
        drive(ld, uns, sz, a, wd);
        #1;
        if ((a % n) != 0) begin
            chk("misalign", lsu_misalign_o, 1);
            chk("mis_stall", lsu_stall_o, 0);
            @(negedge clk_i); #1;
            release_req();
            repeat (5) begin @(negedge clk_i); #1; chk("mis_noreq", mem_req_vld_o, 0); end
        end else begin
            chk("acc_misalign", lsu_misalign_o, 0);
            chk("acc_stall", lsu_stall_o, 1);
            push_exp(ld, uns, sz, a, wd, rw, pw, rword, 1'b1);
            c0 = cyc; dc0 = done_cnt;
            @(negedge clk_i); #1;
            release_req();
            for (int i = 0; i < 60 && done_cnt == dc0; i++) begin @(negedge clk_i); #1; end
            if (done_cnt == dc0) begin
                total++; bad++;
                $display("FAIL done_timeout: got no done want done within 60 cycles");
            end else begin
                chk("latency", done_cyc - c0, ld ? 3 + rw + pw : 2 + rw);
            end
        end
    endtask

    task automatic wait_hs(input int h0);
        for (int i = 0; i < 50 && hs_cnt == h0; i++) begin @(negedge clk_i); #1; end
        if (hs_cnt == h0) begin
            total++; bad++;
            $display("FAIL hs_timeout: got no handshake want one within 50 cycles");
        end
    endtask

    initial begin
        int h0, dc0;
        logic [1:0] sz;
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_stall", lsu_stall_o, 0);
        chk("rst_done", lsu_done_o, 0);
        chk("rst_rdata", lsu_rdata_o, 0);
        chk("rst_memvld", mem_req_vld_o, 0);
        chk("rst_wen", mem_req_wen_o, 0);
        rst_n_i = 1'b1;

        issue(0, 0, `LS_SIZE_WORD, 32'h1000, 32'hDEADBEEF, 0, 0, 0);
        issue(0, 0, `LS_SIZE_BYTE, 32'h2003, 32'h000000A5, 3, 0, 0);
        issue(1, 0, `LS_SIZE_BYTE, 32'h3001, 0, 0, 0, 32'h123480FF);
        chk("lit_sbyte", lsu_rdata_o, 32'hFFFFFF80);
        issue(1, 1, `LS_SIZE_BYTE, 32'h3001, 0, 1, 2, 32'h123480FF);
        chk("lit_ubyte", lsu_rdata_o, 32'h00000080);
        issue(1, 0, `LS_SIZE_HALF, 32'h3002, 0, 0, 1, 32'h123480FF);
        chk("lit_shalf", lsu_rdata_o, 32'h00001234);
        issue(0, 0, `LS_SIZE_HALF, 32'h2002, 32'h0000BEEF, 0, 0, 0);
        chk("store_holds_rdata", lsu_rdata_o, 32'h00001234);
        issue(1, 0, `LS_SIZE_WORD, 32'h4002, 0, 0, 0, 0);

        // Flush while IDLE: request ignored.
        @(negedge clk_i); #1;
        drive(0, 0, `LS_SIZE_WORD, 32'h5000, 32'h11111111); flush_i = 1'b1; #1;
        chk("fidle_stall", lsu_stall_o, 0);
        chk("fidle_mis", lsu_misalign_o, 0);
        @(negedge clk_i); #1; release_req(); flush_i = 1'b0;
        repeat (3) begin @(negedge clk_i); #1; chk("fidle_noreq", mem_req_vld_o, 0); end

        // Flush during a stalled REQ: abort without handshake or done.
        @(negedge clk_i); #1;
        drive(0, 0, `LS_SIZE_WORD, 32'h5004, 32'h22222222); #1;
        push_exp(0, 0, `LS_SIZE_WORD, 32'h5004, 32'h22222222, 1000, 0, 0, 1'b0);
        dc0 = done_cnt;
        @(negedge clk_i); #1; release_req();
        chk("freq_vld", mem_req_vld_o, 1);
        flush_i = 1'b1;
        @(negedge clk_i); #1; flush_i = 1'b0;
        chk("freq_abort_vld", mem_req_vld_o, 0);
        chk("freq_abort_stall", lsu_stall_o, 0);
        if (exp_req.size() != 0) void'(exp_req.pop_front());
        repeat (4) begin @(negedge clk_i); #1; chk("freq_noreq", mem_req_vld_o, 0); end
        chk("freq_nodone", done_cnt - dc0, 0);

        // Flush during RESP: response consumed silently, next load normal.
        @(negedge clk_i); #1;
        h0 = hs_cnt; dc0 = done_cnt;
        drive(1, 0, `LS_SIZE_WORD, 32'h6000, 0); #1;
        push_exp(1, 0, `LS_SIZE_WORD, 32'h6000, 0, 0, 2, 32'hCAFEF00D, 1'b0);
        @(negedge clk_i); #1; release_req();
        wait_hs(h0);
        @(negedge clk_i); #1;
        flush_i = 1'b1;
        chk("fresp_stall", lsu_stall_o, 1);
        @(negedge clk_i); #1; flush_i = 1'b0;
        repeat (5) @(negedge clk_i);
        #1;
        chk("fresp_nodone", done_cnt - dc0, 0);
        chk("fresp_consumed", rspd_q.size(), 0);
        chk("fresp_idle", lsu_stall_o, 0);
        chk("fresp_rdata_kept", lsu_rdata_o, 32'h00001234);
        issue(1, 1, `LS_SIZE_HALF, 32'h6002, 0, 1, 0, 32'h8765ABCD);
        chk("lit_uhalf", lsu_rdata_o, 32'h00008765);

        // Reset asserted in RESP.
        @(negedge clk_i); #1;
        h0 = hs_cnt;
        drive(1, 0, `LS_SIZE_WORD, 32'h7000, 0); #1;
        push_exp(1, 0, `LS_SIZE_WORD, 32'h7000, 0, 0, 20, 32'h01020304, 1'b1);
        @(negedge clk_i); #1; release_req();
        wait_hs(h0);
        @(negedge clk_i); #1;
        chk("rresp_stall", lsu_stall_o, 1);
        #1 rst_n_i = 1'b0;
        #1;
        chk("arst_stall", lsu_stall_o, 0);
        chk("arst_rdata", lsu_rdata_o, 0);
        chk("arst_memvld", mem_req_vld_o, 0);
        chk("arst_addr", mem_req_addr_o, 0);
        chk("arst_wdata", mem_req_wdata_o, 0);
        chk("arst_done", lsu_done_o, 0);
        exp_req.delete(); exp_done.delete(); rdyw_q.delete(); rspw_q.delete(); rspd_q.delete();
        last_load = '0;
        @(negedge clk_i); #1 rst_n_i = 1'b1;
        issue(1, 0, `LS_SIZE_WORD, 32'h7004, 0, 0, 0, 32'h5A5AC3C3);
        chk("lit_word_after_rst", lsu_rdata_o, 32'h5A5AC3C3);

        // Randomized traffic.
        for (int k = 0; k < 80; k++) begin
            sz = 2'($urandom_range(0, 2));
            issue(1'($urandom), 1'($urandom), sz, $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        repeat (3) @(negedge clk_i);
        chk("end_queues", exp_done.size() + exp_req.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/k423_lsu_ctrl.md
# k423_lsu_ctrl

Sequencing controller between the EX-stage load/store unit and the data-memory port. It accepts one decoded memory operation at a time and holds it stable through a valid/ready request handshake. For loads it waits for the response and returns lane-aligned, sign- or zero-extended data. It stalls the pipeline for the whole transaction, flags misaligned accesses without touching memory, and drops in-flight operations on a pipeline flush.

## Interface
Parameters:
- ADDR_W, 32, address width
- XLEN, 32, data width (4 byte lanes)

Ports:
- clk_i  in  1  core clock
- rst_n_i  in  1  reset; asynchronous, active-low
- lsu_req_vld_i  in  1  EX stage presents a memory op
- lsu_req_load_i  in  1  1 = load, 0 = store
- lsu_req_unsigned_i  in  1  zero-extend load result
- lsu_req_size_i  in  `LS_SIZE_W  `LS_SIZE_BYTE/HALF/WORD`
- lsu_req_addr_i  in  ADDR_W  effective byte address
- lsu_req_wdata_i  in  XLEN  store data, right-justified
- flush_i  in  1  pipeline flush
- lsu_stall_o  out  1  hold EX stage
- lsu_done_o  out  1  one-cycle completion pulse
- lsu_rdata_o  out  XLEN  aligned load result, valid with lsu_done_o
- lsu_misalign_o  out  1  misaligned access detected
- mem_req_vld_o  out  1  memory request valid
- mem_req_wen_o  out  4  byte write enables; 0 = read
- mem_req_addr_o  out  ADDR_W  word-aligned address (bits [1:0] = 0)
- mem_req_wdata_o  out  XLEN  lane-positioned store data
- mem_req_rdy_i  in  1  memory accepts request
- mem_rsp_vld_i  in  1  read data valid
- mem_rsp_rdata_i  in  XLEN  read data word

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - Misaligned request (half with addr[0]=1; word with addr[1:0]≠0): lsu_misalign_o=1 combinationally, no stall, no memory access, stay IDLE.
  - Aligned request: register op/addr/size/unsigned/wdata, go to REQ. lsu_stall_o=1 in the accepting cycle.
- REQ:
  - mem_req_vld_o=1 with the registered fields; fields held stable until mem_req_rdy_i.
  - On handshake, a store goes to DONE and a load goes to RESP.
- RESP: wait for mem_rsp_vld_i. On arrival, capture the aligned result and go to DONE.
- DONE: lsu_done_o=1 and lsu_stall_o=0 for one cycle, then return to IDLE. lsu_req_vld_i is ignored in DONE.
- lsu_stall_o = (IDLE & lsu_req_vld_i & aligned) | REQ | RESP.
- Store lanes, with off = addr[1:0]:
  - wen = base << off, where base is 0001 (byte), 0011 (half) or 1111 (word).
  - wdata = {4{b[7:0]}} for byte, {2{h[15:0]}} for half, unchanged for word.
- Load alignment:
  - s = mem_rsp_rdata_i >> (8·off).
  - Byte result is s[7:0] and half result is s[15:0], each extended by lsu_req_unsigned_i (sign-extend when 0). Word result is s.
- Flush:
  - In IDLE: the request is ignored.
  - In REQ before the handshake: abort to IDLE with no done and no memory effect.
  - In REQ on the same cycle as the handshake: the request is issued. A store goes to IDLE with no done pulse. A load goes to RESP with a kill flag set.
  - In RESP: set the kill flag. The response is still consumed, then the FSM returns to IDLE without done.
  - In DONE: no effect.
- Only one transaction is outstanding at a time. mem_rsp_vld_i outside RESP is ignored.

## Timing
- Reset values: state IDLE; kill flag 0; all outputs 0; lsu_rdata_o 0. Asserting reset mid-transaction returns to IDLE immediately, and the memory side sees mem_req_vld_o drop.
- Store latency with rdy=1: accept at cycle T, request at T+1, done at T+2. Every cycle rdy is low adds one cycle.
- Load latency with rdy=1 and the response one cycle after the handshake: accept T, request T+1, RESP T+2, done T+3. Every response wait cycle adds one cycle.
- lsu_rdata_o is registered and holds its value until the next load completes.
- mem_req_* outputs are registered from state. They are never combinational from lsu_req_*.

## Test plan
- Word store, addr 0x1000, wdata 0xDEADBEEF, rdy=1 → T+1: vld=1, wen=1111, addr=0x1000, wdata=0xDEADBEEF; T+2: done=1, stall=0.
- Byte store, addr 0x2003, wdata 0x000000A5, rdy held low 3 cycles → wen=1000 and wdata=0xA5A5A5A5, both held stable for 4 request cycles; done one cycle after rdy.
- Signed byte load, addr 0x3001, rdata 0x1234_80FF → lsu_rdata_o=0xFFFFFF80. The same load with unsigned=1 → 0x00000080. Signed half load at 0x3002 → 0x00001234.
- Misaligned word load at 0x4002 → misalign_o=1 in the same cycle, stall=0, mem_req_vld_o stays 0 for the following 5 cycles.
- Flush during a stalled REQ (rdy=0) → returns to IDLE, no done pulse, no handshake occurs. Flush during RESP → the response arriving 2 cycles later is consumed with no done pulse, and the next load completes normally.
- Reset asserted in RESP → all outputs 0 asynchronously. After release, a new word load completes with correct data.
